// File: rtl/i2s_dac_tx.sv
// i2s_dac_tx: stereo sample FIFO feeding a serial DAC link (mclk/sclk/lrck/sdti).
// One free-running counter derives every DAC clock; once per frame a 64-bit
// shift register is loaded from the FIFO head and shifted out MSB first.
// Optional feature: define I2S_DAC_TX_MUTE_EN to add a 'mute' input that
// loads zero frames while the FIFO keeps draining.
module i2s_dac_tx #(
  parameter int SAMPLE_W  = 16,
  parameter int MODE      = 0,
  parameter int RJ_W      = 20,
  parameter int MCLK_LOG2 = 2,
  parameter int SCLK_LOG2 = 4,
  parameter int FIFO_LOG2 = 2
) (
  input  logic                clk,
  input  logic                reset,
`ifdef I2S_DAC_TX_MUTE_EN
  input  logic                mute,
`endif
  input  logic [SAMPLE_W-1:0] in_l,
  input  logic [SAMPLE_W-1:0] in_r,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [FIFO_LOG2:0]  level,
  output logic                underrun,
  output logic                mclk,
  output logic                sclk,
  output logic                lrck,
  output logic                sdti
);

  localparam int CW    = SCLK_LOG2 + 7;
  localparam int DEPTH = 1 << FIFO_LOG2;
  localparam int PW    = 2 * SAMPLE_W;
  localparam logic [FIFO_LOG2:0] LEVEL_FULL = {1'b1, {FIFO_LOG2{1'b0}}};

  logic [CW-1:0]        r_timing;
  logic [63:0]          r_shift;
  logic [PW-1:0]        r_mem [DEPTH];
  logic [FIFO_LOG2-1:0] r_rd_ptr;
  logic [FIFO_LOG2-1:0] r_wr_ptr;
  logic [FIFO_LOG2:0]   r_level;

  logic                 w_load;
  logic                 w_shift;
  logic                 w_empty;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_mute;
  logic [PW-1:0]        w_head;
  logic [63:0]          w_frame;

  // Place one sample into a 32-bit slot according to the serial format.
  function automatic logic [31:0] f_slot(input logic [SAMPLE_W-1:0] s);
    logic [31:0] sx;
    logic [31:0] mask;
    sx   = {{(32-SAMPLE_W){s[SAMPLE_W-1]}}, s};
    mask = (RJ_W >= 32) ? 32'hFFFF_FFFF : 32'((64'd1 << RJ_W) - 64'd1);
    case (MODE)
      1:       f_slot = {1'b0, s, {(31-SAMPLE_W){1'b0}}};
      2:       f_slot = sx & mask;
      default: f_slot = {s, {(32-SAMPLE_W){1'b0}}};
    endcase
  endfunction

`ifdef I2S_DAC_TX_MUTE_EN
  assign w_mute = mute;
`else
  assign w_mute = 1'b0;
`endif

  // Frame load on the last counter value; shifts on each sclk falling transition.
  assign w_load  = (r_timing == {CW{1'b1}});
  assign w_shift = (r_timing[SCLK_LOG2:0] == {(SCLK_LOG2+1){1'b1}}) && !w_load;

  // A full FIFO refuses pushes even when a pop happens the same cycle, since
  // in_ready looks only at the registered level.
  assign w_empty  = (r_level == '0);
  assign in_ready = (r_level < LEVEL_FULL);
  assign w_push   = in_valid && in_ready;
  assign w_pop    = w_load && !w_empty;

  assign w_head  = r_mem[r_rd_ptr];
  assign w_frame = (w_empty || w_mute) ? 64'd0
                 : {f_slot(w_head[PW-1 -: SAMPLE_W]), f_slot(w_head[SAMPLE_W-1:0])};

  assign mclk     = r_timing[MCLK_LOG2];
  assign sclk     = r_timing[SCLK_LOG2];
  assign lrck     = r_timing[CW-1];
  assign sdti     = r_shift[63];
  assign level    = r_level;
  assign underrun = w_load && w_empty && !reset;

  // Free-running frame counter; every DAC clock is a bit of it.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every block sees
    // the pre-edge values of all registers, independent of evaluation order.
    if (reset) r_timing <= '0;
    else       r_timing <= r_timing + 1'b1;
  end

  // Output shift register: load a whole frame, then shift out MSB first.
  always_ff @(posedge clk) begin
    if (reset)        r_shift <= '0;
    else if (w_load)  r_shift <= w_frame;
    else if (w_shift) r_shift <= {r_shift[62:0], 1'b0};
  end

  // FIFO storage written on an accepted push.
  always_ff @(posedge clk) begin
    // NOTE: the sample array has no reset; stale entries are never read because
    // the pointers and level are reset and gate every access.
    if (w_push) r_mem[r_wr_ptr] <= {in_l, in_r};
  end

  // FIFO pointers and occupancy; pointers wrap naturally at their width.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

endmodule
